if_id_skid_reg: RTL and testbench

Parametrised IF/ID pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It sits between the fetch unit and the decoder of the RISC-V core. It carries the PC, the instruction and the branch-prediction bit. It lets fetch and decode stall independently at full throughput, with no combinational ready path.

---
 rtl/riscv_pipe_pkg.sv | 22 ++
 rtl/pipe_sat_counter.sv | 22 ++
 rtl/if_id_skid_reg.sv | 137 +++++++++++++
 tb/tb_if_id_skid_reg.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RISC-V core: bubble instruction,
// skid-buffer state encoding and the IF/ID payload layout.
package riscv_pipe_pkg;

  // RV32I bubble: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Occupancy of a two-entry skid stage.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // main invalid
    S_BUSY  = 2'd1,  // main valid, skid invalid
    S_FULL  = 2'd2   // main and skid valid
  } skid_state_e;

  // IF/ID payload at the core's native 32-bit widths.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
  } if_id_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter. Counts cycles with inc = 1, sticks at all-ones,
// and clears only on reset. Shared by pipeline stages for statistics.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc until the counter reaches all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake and a two-entry skid
// buffer. in_ready and out_valid come straight from flops, so there is no
// combinational path from any input to any output. Synchronous flush kills
// both held entries and puts a bubble on the decode side.
// Optional statistics counters are built when IF_ID_STATS_EN is defined.
module if_id_skid_reg #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(riscv_pipe_pkg::NOP_INSTR),
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [ILEN-1:0]  in_instr,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [ILEN-1:0]  out_instr,
  output logic             out_pred_taken
`ifdef IF_ID_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  import riscv_pipe_pkg::*;

  // Payload sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred_taken;
  } payload_t;

  skid_state_e state_q, state_d;
  payload_t    main_q, main_d;
  payload_t    skid_q, skid_d;
  payload_t    in_entry;
  logic        valid_q, ready_q;
  logic        accept, pop;

  assign in_entry = '{pc: in_pc, instr: in_instr, pred_taken: in_pred_taken};
  assign accept   = in_valid & ready_q;
  assign pop      = valid_q & out_ready;

  // Next-state and storage update; flush overrides every other event.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d           = S_EMPTY;
      skid_d            = '0;
      main_d.instr      = NOP_INSTR;
      main_d.pred_taken = 1'b0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_BUSY;
            main_d  = in_entry;
          end
        end
        S_BUSY: begin
          if (accept && !pop) begin
            state_d = S_FULL;
            skid_d  = in_entry;
          end else if (accept && pop) begin
            main_d  = in_entry;
          end else if (pop) begin
            // Draining to empty leaves a bubble but keeps the last PC.
            state_d           = S_EMPTY;
            main_d.instr      = NOP_INSTR;
            main_d.pred_taken = 1'b0;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_d = S_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State, storage and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '{pc: '0, instr: NOP_INSTR, pred_taken: 1'b0};
      // NOTE: the skid payload is reset too, so a stale entry can never leak
      // into main after reset even though skid validity is tracked by state.
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != S_EMPTY);
      ready_q <= (state_d != S_FULL);
    end
  end

  assign in_ready       = ready_q;
  assign out_valid      = valid_q;
  assign out_pc         = main_q.pc;
  assign out_instr      = main_q.instr;
  assign out_pred_taken = main_q.pred_taken;

`ifdef IF_ID_STATS_EN
  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (valid_q & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg. A queue-based model (at most two
// held entries, FIFO order, flush empties it) predicts every output.
module tb_if_id_skid_reg;

  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready, in_pred_taken;
  logic [31:0] in_pc, in_instr;
  logic        out_valid, out_ready, out_pred_taken;
  logic [31:0] out_pc, out_instr;
`ifdef IF_ID_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  if_id_skid_reg #(.XLEN(32), .ILEN(32), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .in_pred_taken  (in_pred_taken),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_pred_taken (out_pred_taken)
`ifdef IF_ID_STATS_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } entry_t;

  entry_t      q[$];
  logic [31:0] hold_pc;
  int          stall_exp, flush_exp;

  function automatic logic m_valid();
    return q.size() > 0;
  endfunction
  function automatic logic m_ready();
    return q.size() < 2;
  endfunction
  function automatic logic [31:0] m_pc();
    return (q.size() > 0) ? q[0].pc : hold_pc;
  endfunction
  function automatic logic [31:0] m_instr();
    return (q.size() > 0) ? q[0].instr : NOP;
  endfunction
  function automatic logic m_pred();
    return (q.size() > 0) ? q[0].pred : 1'b0;
  endfunction

  // Advance DUT and model by one clock; returns 1 ns after the edge.
  task automatic cycle();
    logic   acc, pp;
    entry_t e;
    acc = in_valid && m_ready();
    pp  = m_valid() && out_ready;
    e   = '{pc: in_pc, instr: in_instr, pred: in_pred_taken};
    if (m_valid() && !out_ready && stall_exp < (1 << CNT_W) - 1) stall_exp++;
    if (flush && flush_exp < (1 << CNT_W) - 1) flush_exp++;
    @(posedge clk);
    if (flush) begin
      hold_pc = m_pc();
      q.delete();
    end else begin
      if (pp) begin
        hold_pc = q[0].pc;
        void'(q.pop_front());
      end
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic pt, input logic rdy, input logic fl);
    in_valid = v; in_pc = pc; in_instr = ins; in_pred_taken = pt;
    out_ready = rdy; flush = fl;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    q.delete();
    hold_pc = '0; stall_exp = 0; flush_exp = 0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Fill both entries, then pulse reset with no clock edge.
    drive(1'b1, 32'h40, 32'h11, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h44, 32'h22, 1'b0, 1'b0, 1'b0); cycle();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_prefull in_ready got %b exp 0", in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    checks++;
    if (out_instr !== NOP) begin errors++; $display("FAIL reset out_instr got %h exp %h", out_instr, NOP); end
    checks++;
    if (out_pc !== 32'h0) begin errors++; $display("FAIL reset out_pc got %h exp 0", out_pc); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
    checks++;
    if (out_pred_taken !== 1'b0) begin errors++; $display("FAIL reset out_pred got %b exp 0", out_pred_taken); end
`ifdef IF_ID_STATS_EN
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL reset counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
    end
`endif
    apply_reset();
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    ins[0] = 32'h0050_0093; ins[1] = 32'h00A0_0113; ins[2] = 32'h0020_81B3;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], ins[i], 1'b0, 1'b1, 1'b0);
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== ins[i]) begin
        errors++;
        $display("FAIL stream[%0d] got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                 i, out_valid, out_pc, out_instr, pcs[i], ins[i]);
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h8) begin
      errors++;
      $display("FAIL stream_drain got v=%b pc=%h ins=%h exp v=0 pc=8 ins=%h",
               out_valid, out_pc, out_instr, NOP);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] order [3];
    order[0] = 32'h100; order[1] = 32'h104; order[2] = 32'h108;
    drive(1'b1, 32'h100, 32'hA, 1'b1, 1'b0, 1'b0); cycle();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first in_ready got %b exp 1", in_ready); end
    drive(1'b1, 32'h104, 32'hB, 1'b0, 1'b0, 1'b0); cycle();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full in_ready got %b exp 0", in_ready); end
    drive(1'b1, 32'h108, 32'hC, 1'b1, 1'b0, 1'b0); cycle();
    checks++;
    if (in_ready !== 1'b0 || out_pc !== 32'h100 || out_pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got rdy=%b pc=%h pt=%b exp rdy=0 pc=100 pt=1", in_ready, out_pc, out_pred_taken);
    end
    // Keep offering 0x108 while the decoder drains.
    drive(1'b1, 32'h108, 32'hC, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 3; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== order[i]) begin
        errors++;
        $display("FAIL bp_order[%0d] got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, order[i]);
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_accept_pop();
    drive(1'b1, 32'h500, 32'h55, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h504, 32'h66, 1'b1, 1'b1, 1'b0); cycle();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_pc !== 32'h504 || out_instr !== 32'h66) begin
      errors++;
      $display("FAIL acc_pop got v=%b rdy=%b pc=%h ins=%h exp v=1 rdy=1 pc=504 ins=66",
               out_valid, in_ready, out_pc, out_instr);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h1F0, 32'h77, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h1F4, 32'h88, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h200, 32'h99, 1'b1, 1'b1, 1'b1); cycle();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1 ||
        out_pred_taken !== 1'b0 || out_pc !== 32'h1F0) begin
      errors++;
      $display("FAIL flush got v=%b ins=%h rdy=%b pt=%b pc=%h exp v=0 ins=%h rdy=1 pt=0 pc=1f0",
               out_valid, out_instr, in_ready, out_pred_taken, out_pc, NOP);
    end
`ifdef IF_ID_STATS_EN
    checks++;
    if (flush_cnt !== CNT_W'(flush_exp)) begin
      errors++; $display("FAIL flush_cnt got %0d exp %0d", flush_cnt, flush_exp);
    end
`endif
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard out_valid got %b exp 0", out_valid); end
    // Accept right after a flush.
    drive(1'b1, 32'h300, 32'hAB, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 32'h304, 32'hCD, 1'b0, 1'b1, 1'b0); cycle();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h304) begin
      errors++; $display("FAIL post_flush got v=%b pc=%h exp v=1 pc=304", out_valid, out_pc);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
  endtask

  task automatic test_stall_saturate();
    apply_reset();
    drive(1'b1, 32'h600, 32'hEE, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h600) begin
      errors++; $display("FAIL stall_hold got v=%b pc=%h exp v=1 pc=600", out_valid, out_pc);
    end
`ifdef IF_ID_STATS_EN
    checks++;
    if (stall_cnt !== 4'hF || stall_exp != 15) begin
      errors++; $display("FAIL stall_sat got %0d exp 15 (model %0d)", stall_cnt, stall_exp);
    end
`endif
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, $urandom, $urandom_range(0, 1),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      cycle();
      checks++;
      if (out_valid !== m_valid() || in_ready !== m_ready() || out_pc !== m_pc() ||
          out_instr !== m_instr() || out_pred_taken !== m_pred()) begin
        errors++;
        $display("FAIL rand[%0d] got v=%b r=%b pc=%h ins=%h pt=%b exp v=%b r=%b pc=%h ins=%h pt=%b",
                 i, out_valid, in_ready, out_pc, out_instr, out_pred_taken,
                 m_valid(), m_ready(), m_pc(), m_instr(), m_pred());
      end
`ifdef IF_ID_STATS_EN
      checks++;
      if (stall_cnt !== CNT_W'(stall_exp) || flush_cnt !== CNT_W'(flush_exp)) begin
        errors++;
        $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", i, stall_cnt, flush_cnt, stall_exp, flush_exp);
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    q.delete(); hold_pc = '0; stall_exp = 0; flush_exp = 0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_accept_pop();
    test_flush();
    test_stall_saturate();
    apply_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
